// File: rtl/usb_tx_bitenc.sv
// USB transmit bit encoder: SYNC insertion, bit stuffing and NRZI.
// Emits one registered line level per cycle to the line driver.
module usb_tx_bitenc (
  input  logic clk,
  input  logic rst,
  input  logic in_bit,
  input  logic in_valid,
  input  logic in_last,
  output logic in_ready,
  input  logic tx_ready,
  output logic data_bit,
  output logic data_start,
  output logic data_end,
  output logic busy,
  output logic underrun
);

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    DATA,
    STUFF,
    ABORT,
    DISCARD
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic       lvl;
  logic       lvl_nx;
  logic [2:0] ones;
  logic [2:0] ones_nx;
  logic [2:0] cnt;
  logic [2:0] cnt_nx;
  logic       last_q;
  logic       last_nx;
  logic       bit_nx;
  logic       start_nx;
  logic       end_nx;
  logic       busy_nx;
  logic       urun_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      lvl        <= 1'b1;
      ones       <= 3'd0;
      cnt        <= 3'd0;
      last_q     <= 1'b0;
      data_bit   <= 1'b1;
      data_start <= 1'b0;
      data_end   <= 1'b0;
      busy       <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      state      <= state_nx;
      lvl        <= lvl_nx;
      ones       <= ones_nx;
      cnt        <= cnt_nx;
      last_q     <= last_nx;
      data_bit   <= bit_nx;
      data_start <= start_nx;
      data_end   <= end_nx;
      busy       <= busy_nx;
      underrun   <= urun_nx;
    end
  end

  always_comb begin
    state_nx = state;
    lvl_nx   = lvl;
    ones_nx  = ones;
    cnt_nx   = cnt;
    last_nx  = last_q;
    bit_nx   = 1'b1;
    start_nx = 1'b0;
    end_nx   = 1'b0;
    busy_nx  = busy;
    urun_nx  = 1'b0;
    in_ready = 1'b0;
    unique case (state)
      IDLE: begin
        busy_nx = 1'b0;
        if (in_valid && tx_ready) begin
          // first SYNC bit is a raw 0 toggling from J
          state_nx = SYNC;
          lvl_nx   = 1'b0;
          bit_nx   = 1'b0;
          start_nx = 1'b1;
          busy_nx  = 1'b1;
          ones_nx  = 3'd0;
          cnt_nx   = 3'd1;
          last_nx  = 1'b0;
        end
      end
      SYNC: begin
        if (cnt == 3'd7) begin
          bit_nx   = lvl;
          ones_nx  = 3'd1;
          state_nx = DATA;
        end else begin
          lvl_nx = ~lvl;
          bit_nx = ~lvl;
          cnt_nx = cnt + 3'd1;
        end
      end
      DATA: begin
        in_ready = 1'b1;
        if (in_valid) begin
          lvl_nx  = in_bit ? lvl : ~lvl;
          ones_nx = in_bit ? ones + 3'd1 : 3'd0;
          bit_nx  = in_bit ? lvl : ~lvl;
          if (in_bit && ones == 3'd5) begin
            state_nx = STUFF;
            last_nx  = in_last;
          end else if (in_last) begin
            end_nx   = 1'b1;
            state_nx = IDLE;
          end
        end else begin
          // starved mid-packet: close the line with a held bit
          bit_nx   = lvl;
          end_nx   = 1'b1;
          urun_nx  = 1'b1;
          last_nx  = 1'b0;
          state_nx = ABORT;
        end
      end
      STUFF: begin
        lvl_nx  = ~lvl;
        bit_nx  = ~lvl;
        ones_nx = 3'd0;
        if (last_q) begin
          end_nx   = 1'b1;
          state_nx = IDLE;
        end else begin
          state_nx = DATA;
        end
      end
      ABORT: begin
        busy_nx  = 1'b0;
        state_nx = last_q ? IDLE : DISCARD;
      end
      DISCARD: begin
        busy_nx  = 1'b0;
        in_ready = 1'b1;
        if (in_valid && in_last) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_usb_tx_bitenc.sv
// Self-checking bench for usb_tx_bitenc.
// Reference model: SYNC + stuffing + NRZI on bit queues.
module tb_usb_tx_bitenc;

  logic clk = 1'b0;
  logic rst;
  logic in_bit;
  logic in_valid;
  logic in_last;
  logic in_ready;
  logic tx_ready;
  logic data_bit;
  logic data_start;
  logic data_end;
  logic busy;
  logic underrun;

  int total = 0;
  int bad = 0;
  bit mon_en = 1'b0;
  logic [3:0] em[$];
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  usb_tx_bitenc dut (
    .clk(clk),
    .rst(rst),
    .in_bit(in_bit),
    .in_valid(in_valid),
    .in_last(in_last),
    .in_ready(in_ready),
    .tx_ready(tx_ready),
    .data_bit(data_bit),
    .data_start(data_start),
    .data_end(data_end),
    .busy(busy),
    .underrun(underrun)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, expv);
    end
  endtask

  // entries are {level, start, end, underrun}
  always @(negedge clk) begin
    if (mon_en) begin
      if (busy === 1'b1)
        em.push_back({data_bit, data_start,
                      data_end, underrun});
      else
        chk("idle_out", {data_bit, data_start,
                         data_end, underrun}, 4'b1000);
    end
  end

  task automatic build_exp(input bit raw[$], input bit ur);
    bit s[$];
    bit t[$];
    int ones = 0;
    bit lv = 1'b1;
    logic [3:0] e;
    for (int i = 0; i < 7; i++) s.push_back(1'b0);
    s.push_back(1'b1);
    foreach (raw[i]) s.push_back(raw[i]);
    foreach (s[i]) begin
      t.push_back(s[i]);
      if (s[i]) begin
        ones++;
        if (ones == 6) begin
          t.push_back(1'b0);
          ones = 0;
        end
      end else begin
        ones = 0;
      end
    end
    exp_q.delete();
    foreach (t[i]) begin
      if (!t[i]) lv = ~lv;
      exp_q.push_back({lv, 3'b000});
    end
    if (ur) exp_q.push_back({lv, 3'b001});
    e = exp_q[0];
    e[2] = 1'b1;
    exp_q[0] = e;
    e = exp_q[exp_q.size()-1];
    e[1] = 1'b1;
    exp_q[exp_q.size()-1] = e;
  endtask

  task automatic check_pkt(input string tag);
    int n;
    chk({tag, "_len"}, em.size(), exp_q.size());
    n = (em.size() < exp_q.size()) ? em.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s[%0d]", tag, i), em[i], exp_q[i]);
    em.delete();
  endtask

  // drop_at >= 0: in_valid low 2 cycles after that many accepts
  task automatic send(input string tag, input bit raw[$],
                      input int drop_at);
    int idx = 0;
    int guard = 0;
    bit dropped = 1'b0;
    bit rdy;
    while (idx < raw.size() && guard < 2000) begin
      @(negedge clk);
      if (drop_at >= 0 && idx == drop_at && !dropped) begin
        in_valid = 1'b0;
        in_last = 1'b0;
        dropped = 1'b1;
        repeat (2) @(negedge clk);
      end
      tx_ready = 1'b1;
      in_valid = 1'b1;
      in_bit = raw[idx];
      in_last = (idx == raw.size() - 1);
      rdy = in_ready;
      @(posedge clk);
      if (rdy) idx++;
      guard++;
    end
    chk({tag, "_accept"}, idx, raw.size());
    @(negedge clk);
    in_valid = 1'b0;
    in_last = 1'b0;
    guard = 0;
    while (busy !== 1'b0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk({tag, "_done"}, busy, 1'b0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    bit raw[$];
    bit pre[$];
    int g;
    rst = 1'b1;
    in_valid = 1'b0;
    in_bit = 1'b0;
    in_last = 1'b0;
    tx_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out", {data_bit, data_start, data_end,
                    busy, underrun, in_ready}, 6'b100000);
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    raw = '{0, 0, 0, 0, 0, 0, 0, 0};
    send("zeros", raw, -1);
    build_exp(raw, 1'b0);
    check_pkt("zeros");

    raw = '{1, 1, 1, 1, 1, 1, 0};
    send("stuff", raw, -1);
    build_exp(raw, 1'b0);
    check_pkt("stuff");

    raw = '{1, 1, 1, 1, 1};
    send("stufflast", raw, -1);
    build_exp(raw, 1'b0);
    check_pkt("stufflast");

    raw = '{1};
    send("single", raw, -1);
    build_exp(raw, 1'b0);
    check_pkt("single");

    raw.delete();
    pre.delete();
    for (int i = 0; i < 8; i++) raw.push_back(1'($urandom));
    for (int i = 0; i < 3; i++) pre.push_back(raw[i]);
    send("urun", raw, 3);
    build_exp(pre, 1'b1);
    check_pkt("urun");
    chk("urun_idle_rdy", in_ready, 1'b0);

    raw = '{0, 1, 1, 0};
    send("post_urun", raw, -1);
    build_exp(raw, 1'b0);
    check_pkt("post_urun");

    tx_ready = 1'b0;
    in_valid = 1'b1;
    in_bit = 1'b1;
    in_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("txr_wait", {busy, in_ready}, 2'b00);
    end
    chk("txr_quiet", em.size(), 0);
    raw = '{1, 0, 1};
    send("txr", raw, -1);
    build_exp(raw, 1'b0);
    check_pkt("txr");

    in_valid = 1'b1;
    in_last = 1'b0;
    tx_ready = 1'b1;
    g = 0;
    while (in_ready !== 1'b1 && g < 30) begin
      in_bit = 1'($urandom);
      @(negedge clk);
      g++;
    end
    chk("rst_reach_data", in_ready, 1'b1);
    repeat (2) begin
      in_bit = 1'b0;
      @(negedge clk);
    end
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid1", {data_bit, data_start, data_end,
                     busy, underrun, in_ready}, 6'b100000);
    @(negedge clk);
    chk("rst_mid2", {data_bit, data_start, data_end,
                     busy, underrun, in_ready}, 6'b100000);
    rst = 1'b0;
    foreach (em[i]) chk("rst_noend", em[i][1], 1'b0);
    em.delete();
    raw = '{1, 1, 0, 1};
    send("after_rst", raw, -1);
    build_exp(raw, 1'b0);
    check_pkt("after_rst");

    for (int p = 0; p < 8; p++) begin
      raw.delete();
      for (int i = 0; i < $urandom_range(1, 24); i++)
        raw.push_back($urandom_range(0, 3) != 0);
      send($sformatf("rnd%0d", p), raw, -1);
      build_exp(raw, 1'b0);
      check_pkt($sformatf("rnd%0d", p));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/usb_tx_bitenc.md
USB_TX_BITENC -- requirements
Module: usb_tx_bitenc

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all logic on rising edge.
REQ-002 SHALL have ports: rst  in  1  synchronous reset, active-high.
REQ-003 SHALL have ports: in_bit  in  1  raw (pre-stuff, pre-NRZI) packet bit from packet serializer.
REQ-004 SHALL have ports: in_valid  in  1  in_bit valid.
REQ-005 SHALL have ports: in_last  in  1  in_bit is final raw bit of packet.
REQ-006 SHALL have ports: in_ready  out  1  combinational; bit accepted when in_valid && in_ready.
REQ-007 SHALL have ports: tx_ready  in  1  line driver idle and able to start a packet.
REQ-008 SHALL have ports: data_bit  out  1  registered line level to line driver, 1=J, 0=K.
REQ-009 SHALL have ports: data_start  out  1  registered; 1-cycle pulse with first emitted bit.
REQ-010 SHALL have ports: data_end  out  1  registered; 1-cycle pulse with final emitted bit.
REQ-011 SHALL have ports: busy  out  1  registered; high from start accept until the cycle data_end is driven.
REQ-012 SHALL have ports: underrun  out  1  registered; 1-cycle pulse on mid-packet starvation.

Function
REQ-013 SHALL implement FSM states IDLE, SYNC, DATA, STUFF, ABORT, DISCARD.
REQ-014 IDLE: in_ready=0; when in_valid && tx_ready, SHALL go to SYNC, raw bit not consumed.
REQ-015 SYNC SHALL emit raw 0000000_1 (8 cycles) under NRZI, i.e. levels 0,1,0,1,0,1,0,0; data_start=1 on the first only.
REQ-016 NRZI level register SHALL be 1 (J) at packet start; raw 0 toggles level, raw 1 holds it.
REQ-017 Ones counter (3 bits) SHALL count consecutive raw 1s including SYNC's final 1; cleared by any raw 0, including a stuff bit.
REQ-018 DATA: in_ready=1; accepted bit SHALL appear on data_bit the following cycle (latency 1), one emitted bit per cycle, no gaps.
REQ-019 Accepting a raw 1 that brings the ones count to 6 SHALL move to STUFF; STUFF: in_ready=0, next emitted bit is raw 0 (level toggle), then return to DATA.
REQ-020 Accepting in_last SHALL end the packet: data_end on that bit, unless it triggers a stuff, in which case data_end rides on the stuff bit; then IDLE.
REQ-021 In SYNC, STUFF, ABORT, DISCARD and IDLE, in_ready SHALL be 0 except DISCARD (in_ready=1).
REQ-022 DATA with in_valid=0 SHALL be an underrun: next cycle emit one bit at held level with data_end=1 and underrun=1, state ABORT.
REQ-023 ABORT SHALL go to DISCARD if in_last not yet accepted, else IDLE; DISCARD drops bits until in_last accepted, then IDLE.
REQ-024 tx_ready SHALL be ignored outside IDLE; a new packet SHALL not start until tx_ready=1 (line driver's EOP finished).
REQ-025 When no bit is being emitted, data_bit SHALL be 1, data_start=0, data_end=0.
REQ-026 in_last with in_valid in IDLE SHALL still start a normal packet (SYNC then that single bit).

Reset
REQ-027 rst=1 at a clock edge SHALL force IDLE, level=1, ones count=0, data_bit=1, data_start=0, data_end=0, busy=0, underrun=0; in_ready=0.
REQ-028 Reset mid-packet SHALL abandon the packet without emitting data_end; first post-reset packet SHALL begin with full SYNC.

Verification
REQ-029 rst high 2 cycles during DATA -> next cycle all outputs at REQ-027 values, in_ready=0, no data_end.
REQ-030 tx_ready=1, raw 0 x8 with in_last on 8th, in_valid constant -> 16 emitted cycles: 0,1,0,1,0,1,0,0 then 1,0,1,0,1,0,1,0; data_start cycle 1, data_end cycle 16.
REQ-031 Raw 1,1,1,1,1,1,0 (in_last on 0) -> after SYNC emitted 0,0,0,0,0,1(stuff),1,0; in_ready low exactly 1 cycle; data_end on final 0.
REQ-032 Raw 1,1,1,1,1 with in_last on 5th -> emitted 0,0,0,0,0,1(stuff); data_end on stuff bit only.
REQ-033 in_valid dropped after 3 data bits, in_last 2 cycles later -> one extra held-level bit with data_end=1, underrun=1 same cycle; remaining bits swallowed with in_ready=1; FSM in IDLE after in_last.
REQ-034 in_valid=1, tx_ready=0 for 5 cycles then 1 -> no output activity, busy=0, until the cycle after tx_ready rises; then data_start with level 0.
